commit_trace_buffer: RTL

//  Captures the RISCV_core debug commit events: regfile writebacks (regfile_wr_*, thread_index_wb)
//  and dmem stores (o_dmem_*, thread_index_wrmem). Packs each event into a 64-bit trace record.

---
 rtl/commit_trace_buffer_pkg.sv | 47 ++++
 rtl/commit_trace_buffer_if.sv | 44 ++++
 rtl/commit_trace_buffer_fifo.sv | 74 +++++++
 rtl/commit_trace_buffer.sv | 101 ++++++++++
 4 files changed

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types and helpers for the commit trace buffer: the 64-bit trace record layout
// and packing functions for regfile-writeback and store events.
package commit_trace_buffer_pkg;

    localparam int unsigned TRACE_REC_W = 64;

    localparam logic TRACE_TYPE_REG = 1'b0;
    localparam logic TRACE_TYPE_MEM = 1'b1;

    typedef struct packed {
        logic        rec_type;
        logic [2:0]  rsvd_hi;
        logic [3:0]  thread;
        logic [3:0]  byte_en;
        logic [5:0]  rsvd_lo;
        logic [13:0] addr;
        logic [31:0] data;
    } trace_rec_t;

    function automatic trace_rec_t pack_reg_rec(input logic [3:0]  thread,
                                                input logic [4:0]  rd,
                                                input logic [31:0] data);
        trace_rec_t rec;
        rec          = '0;
        rec.rec_type = TRACE_TYPE_REG;
        rec.thread   = thread;
        rec.byte_en  = 4'hF;
        rec.addr     = {9'b0, rd};
        rec.data     = data;
        return rec;
    endfunction

    function automatic trace_rec_t pack_mem_rec(input logic [3:0]  thread,
                                                input logic [3:0]  byte_en,
                                                input logic [13:0] addr,
                                                input logic [31:0] data);
        trace_rec_t rec;
        rec          = '0;
        rec.rec_type = TRACE_TYPE_MEM;
        rec.thread   = thread;
        rec.byte_en  = byte_en;
        rec.addr     = addr;
        rec.data     = data;
        return rec;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Event capture inputs, control and trace drain stream of the commit trace buffer.
// The master modport drives events (core/host side); the slave modport is the buffer.
interface commit_trace_buffer_if
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
);

    logic                     i_enable;
    logic                     i_clear;
    logic [15:0]              i_thread_mask;
    logic                     i_rf_wr_en;
    logic [4:0]               i_rf_wr_addr;
    logic [31:0]              i_rf_wr_data;
    logic [3:0]               i_thread_index_wb;
    logic [3:0]               i_dmem_we;
    logic [13:0]              i_dmem_addr;
    logic [31:0]              i_dmem_wdata;
    logic [3:0]               i_thread_index_wrmem;
    logic                     o_trace_valid;
    logic                     i_trace_ready;
    logic [TRACE_REC_W-1:0]   o_trace_record;
    logic [$clog2(DEPTH):0]   o_fill_level;
    logic [CNT_WIDTH-1:0]     o_drop_count;
    logic                     o_overflow;

    modport master (
        output i_enable, i_clear, i_thread_mask,
        output i_rf_wr_en, i_rf_wr_addr, i_rf_wr_data, i_thread_index_wb,
        output i_dmem_we, i_dmem_addr, i_dmem_wdata, i_thread_index_wrmem,
        output i_trace_ready,
        input  o_trace_valid, o_trace_record, o_fill_level, o_drop_count, o_overflow
    );

    modport slave (
        input  i_enable, i_clear, i_thread_mask,
        input  i_rf_wr_en, i_rf_wr_addr, i_rf_wr_data, i_thread_index_wb,
        input  i_dmem_we, i_dmem_addr, i_dmem_wdata, i_thread_index_wrmem,
        input  i_trace_ready,
        output o_trace_valid, o_trace_record, o_fill_level, o_drop_count, o_overflow
    );

endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// DEPTH-entry register FIFO accepting 0, 1 or 2 records per cycle and popping at most one.
// The head is presented first-word-fall-through and reads as zero while empty.
module commit_trace_buffer_fifo
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned FILL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [1:0]        push_cnt,
    input  trace_rec_t        push_data0,
    input  trace_rec_t        push_data1,
    input  logic              pop,
    output logic              head_valid,
    output trace_rec_t        head_data,
    output logic [FILL_W-1:0] fill
);

    trace_rec_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              do_pop;

    assign do_pop     = pop & (fill_q != '0);
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
            rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
            fill_d   = fill_q + FILL_W'(push_cnt) - FILL_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage is left unreset; the head is masked by head_valid instead.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (push_cnt != 2'd0) begin
                mem_q[wr_ptr_q] <= push_data0;
            end
            if (push_cnt == 2'd2) begin
                mem_q[wr_ptr_nxt] <= push_data1;
            end
        end
    end

    assign head_valid = (fill_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign fill       = fill_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// On-chip commit trace: qualifies regfile writebacks and stores, packs them into 64-bit
// records, buffers them and drains them over a valid/ready stream with drop accounting.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                  clk,
    input logic                  reset,
    commit_trace_buffer_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(DEPTH) + 1;
    localparam logic [FILL_W-1:0] DEPTH_W = FILL_W'(DEPTH);

    logic              reg_evt, mem_evt;
    logic              acc_reg, acc_mem;
    logic [1:0]        push_cnt, drop_cnt;
    logic [FILL_W-1:0] fill, free;
    trace_rec_t        reg_rec, mem_rec, push_data0, push_data1, head_data;
    logic              head_valid, pop;

    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic [CNT_WIDTH:0]   drop_sum;
    logic                 ovf_q, ovf_d;

    always_comb begin
        reg_rec = pack_reg_rec(bus.i_thread_index_wb, bus.i_rf_wr_addr, bus.i_rf_wr_data);
        mem_rec = pack_mem_rec(bus.i_thread_index_wrmem, bus.i_dmem_we, bus.i_dmem_addr,
                               bus.i_dmem_wdata);

        reg_evt = bus.i_enable & bus.i_thread_mask[bus.i_thread_index_wb] & bus.i_rf_wr_en &
                  (bus.i_rf_wr_addr != 5'd0);
        mem_evt = bus.i_enable & bus.i_thread_mask[bus.i_thread_index_wrmem] &
                  (bus.i_dmem_we != 4'd0);

        // Space is judged on the start-of-cycle fill; a same-cycle pop frees nothing.
        free    = DEPTH_W - fill;
        acc_reg = ~bus.i_clear & reg_evt & (free != '0);
        acc_mem = ~bus.i_clear & mem_evt &
                  ((free >= FILL_W'(2)) | ((free == FILL_W'(1)) & ~reg_evt));

        push_cnt = {1'b0, acc_reg} + {1'b0, acc_mem};
        drop_cnt = '0;
        if (!bus.i_clear) begin
            drop_cnt = {1'b0, reg_evt & ~acc_reg} + {1'b0, mem_evt & ~acc_mem};
        end

        // The writeback belongs to the older instruction, so it takes the lower slot.
        push_data0 = acc_reg ? reg_rec : mem_rec;
        push_data1 = mem_rec;
    end

    assign pop = head_valid & bus.i_trace_ready;

    commit_trace_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.i_clear),
        .push_cnt   (push_cnt),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .fill       (fill)
    );

    always_comb begin
        drop_sum = {1'b0, drop_q} + (CNT_WIDTH + 1)'(drop_cnt);
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        if (bus.i_clear) begin
            drop_d = '0;
            ovf_d  = 1'b0;
        end else if (drop_cnt != 2'd0) begin
            drop_d = drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.o_trace_valid  = head_valid;
    assign bus.o_trace_record = head_data;
    assign bus.o_fill_level   = fill;
    assign bus.o_drop_count   = drop_q;
    assign bus.o_overflow     = ovf_q;

endmodule
